// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer.
//   - datapath / register-file geometry
//   - opcode constants and instruction field positions
//   - FSM state enum and an opcode classification helper
// Optional feature macro used by this codebase: ALU_SEQ_R0_ZERO_EN
// (r0 hardwired to zero, handled inside alu_seq_regfile).
package alu_seq_pkg;

    localparam int DATA_W = 16;   // must match the ALU operand/result width
    localparam int NREGS  = 8;    // fixed by the 3-bit register fields
    localparam int OP_W   = 4;
    localparam int REG_AW = 3;
    localparam int IMM_W  = 9;

    // Instruction field positions (LSB of each field)
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RSA_LSB = 6;
    localparam int RSB_LSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_LDI = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_SHR = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL = 4'd7;
    localparam logic [OP_W-1:0] OP_ROR = 4'd8;
    localparam logic [OP_W-1:0] OP_ROL = 4'd9;
    localparam logic [OP_W-1:0] OP_NOT = 4'd10;
    localparam logic [OP_W-1:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    // Opcodes 1..11 go through the ALU; 0 is LDI, 12..15 are NOPs.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus bundle between the instruction source / external ALU and the sequencer.
//   instr, instr_valid, instr_ready : instruction handshake
//   alu_en, alu_opA, alu_opB, alu_oper, alu_q : connection to the registered ALU
//   wb_valid, wb_addr, wb_data : writeback report
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1; the source holds instr stable until that edge, and
// instr_valid seen while instr_ready is 0 is ignored.
// modport slave  : the sequencer side
// modport master : the instruction source / ALU / observer side
interface alu_seq_if;
    import alu_seq_pkg::*;

    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              alu_en;
    logic [DATA_W-1:0] alu_opA;
    logic [DATA_W-1:0] alu_opB;
    logic [OP_W-1:0]   alu_oper;
    logic [DATA_W-1:0] alu_q;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  instr, instr_valid, alu_q,
        output instr_ready, alu_en, alu_opA, alu_opB, alu_oper,
               wb_valid, wb_addr, wb_data
    );

    modport master (
        output instr, instr_valid, alu_q,
        input  instr_ready, alu_en, alu_opA, alu_opB, alu_oper,
               wb_valid, wb_addr, wb_data
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// 8x16 register file: synchronous active-low reset, one write port and three
// combinational read ports (operand A, operand B, debug).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   we, waddr, wdata    write port (takes effect at the rising edge)
//   ra_addr / ra_data   operand A read
//   rb_addr / rb_data   operand B read
//   dbg_addr / dbg_data debug read
// Macro ALU_SEQ_R0_ZERO_EN: r0 reads as zero and writes to r0 are dropped.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_ok;

`ifdef ALU_SEQ_R0_ZERO_EN
    assign wr_ok = we && (waddr != '0);
`else
    assign wr_ok = we;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [REG_AW-1:0] a);
`ifdef ALU_SEQ_R0_ZERO_EN
        if (a == '0) return '0;
`endif
        return regs[a];
    endfunction

    assign ra_data  = rd(ra_addr);
    assign rb_data  = rd(rb_addr);
    assign dbg_data = rd(dbg_addr);

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback stage around a registered 16-bit ALU. Accepts one
// instruction at a time, reads operands from the internal register file,
// drives the ALU for one cycle, then writes the ALU result (or the LDI
// immediate) back to the destination register.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   bus (slave)         instruction handshake, ALU drive/result, writeback report
//   dbg_addr / dbg_data combinational register-file read
//   state_dbg           current FSM state
// Macro ALU_SEQ_R0_ZERO_EN: r0 hardwired to zero (inside alu_seq_regfile).
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_if.slave          bus,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output state_t            state_dbg
);

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rd_q;
    logic [IMM_W-1:0]  imm_q;

    logic              alu_en_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [OP_W-1:0]   oper_q;
    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;

    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] rf_a, rf_b, result;
    logic              rf_we;

    assign in_op = bus.instr[OP_LSB +: OP_W];

    // Only meaningful in WB: LDI writes its zero-extended immediate.
    assign result = (op_q == OP_LDI) ? DATA_W'(imm_q) : bus.alu_q;
    assign rf_we  = (state == S_WB);

    // Operands are read at the accept edge from the incoming instruction, so
    // a source that equals the destination sees the pre-write value.
    alu_seq_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (result),
        .ra_addr  (bus.instr[RSA_LSB +: REG_AW]),
        .ra_data  (rf_a),
        .rb_addr  (bus.instr[RSB_LSB +: REG_AW]),
        .rb_data  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            alu_en_q   <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            oper_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        op_q  <= in_op;
                        rd_q  <= bus.instr[RD_LSB +: REG_AW];
                        imm_q <= bus.instr[IMM_LSB +: IMM_W];
                        if (in_op == OP_LDI) begin
                            state <= S_WB;
                        end else if (is_alu_op(in_op)) begin
                            state    <= S_ISSUE;
                            alu_en_q <= 1'b1;
                            opa_q    <= rf_a;
                            opb_q    <= rf_b;
                            oper_q   <= in_op;
                        end
                        // NOPs are consumed here without leaving IDLE.
                    end
                end
                S_ISSUE: begin
                    alu_en_q <= 1'b0;
                    state    <= S_WB;
                end
                S_WB: begin
                    wb_valid_q <= 1'b1;
                    wb_addr_q  <= rd_q;
                    wb_data_q  <= result;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state == S_IDLE);
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_opA     = opa_q;
    assign bus.alu_opB     = opb_q;
    assign bus.alu_oper    = oper_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    state_t            state_dbg;
    logic [DATA_W-1:0] alu_q_m;

    int total = 0;
    int bad   = 0;
    logic [REG_AW+DATA_W-1:0] exp_q[$];

    alu_seq_if bus ();

    alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- registered ALU stand-in ----------------
    function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
        p = a * b;
        case (op)
            4'd1:    return b + a;
            4'd2:    return b - a;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd11:   return p[DATA_W-1:0];
            default: return '0;
        endcase
    endfunction

    initial alu_q_m = '0;
    always @(posedge clk) if (bus.alu_en) alu_q_m <= alu_f(bus.alu_oper, bus.alu_opA, bus.alu_opB);
    assign bus.alu_q = alu_q_m;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every writeback pulse must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                check("wb_spurious", 32'(bus.wb_valid), 32'd0);
            end else begin
                check("wb_write", 32'({bus.wb_addr, bus.wb_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {OP_LDI, rd, imm};
    endfunction

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] a, input logic [2:0] b);
        return {op, rd, a, b, 3'b000};
    endfunction

    task automatic send(input logic [15:0] w);
        int n = 0;
        while (!bus.instr_ready && n < 10) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(bus.instr_ready), 32'd1);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic run(input logic [15:0] w, input logic [2:0] rd, input logic [15:0] data);
        exp_q.push_back({rd, data});
        send(w);
        repeat (3) tick();
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [15:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n           = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        dbg_addr        = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_alu_en", 32'(bus.alu_en), 32'd0);
        check("rst_opA", 32'(bus.alu_opA), 32'd0);
        check("rst_opB", 32'(bus.alu_opB), 32'd0);
        check("rst_oper", 32'(bus.alu_oper), 32'd0);
        check("rst_wb", 32'({bus.wb_valid, bus.wb_addr, bus.wb_data}), 32'd0);
        for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000, "rst_reg");

        // LDI r1,5 ; LDI r2,3
        run(ldi(3'd1, 9'd5), 3'd1, 16'd5);
        run(ldi(3'd2, 9'd3), 3'd2, 16'd3);

        // ADD r3,r1,r2 with cycle-accurate timing
        exp_q.push_back({3'd3, 16'd8});
        send(rr(OP_ADD, 3'd3, 3'd1, 3'd2));           // now cycle 1 (ISSUE)
        check("add_c1_alu_en", 32'(bus.alu_en), 32'd1);
        check("add_c1_opA", 32'(bus.alu_opA), 32'd5);
        check("add_c1_opB", 32'(bus.alu_opB), 32'd3);
        check("add_c1_oper", 32'(bus.alu_oper), 32'd1);
        check("add_c1_ready", 32'(bus.instr_ready), 32'd0);
        tick();                                        // cycle 2 (WB)
        check("add_c2_alu_en", 32'(bus.alu_en), 32'd0);
        check("add_c2_ready", 32'(bus.instr_ready), 32'd0);
        check("add_c2_wb", 32'(bus.wb_valid), 32'd0);
        check("add_c2_hold_opA", 32'(bus.alu_opA), 32'd5);
        tick();                                        // cycle 3
        check("add_c3_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("add_c3_wb_addr", 32'(bus.wb_addr), 32'd3);
        check("add_c3_wb_data", 32'(bus.wb_data), 32'd8);
        check("add_c3_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        check("add_c4_wb_clear", 32'(bus.wb_valid), 32'd0);
        check("add_c4_wb_hold", 32'({bus.wb_addr, bus.wb_data}), 32'({3'd3, 16'd8}));
        check_reg(3'd3, 16'd8, "dbg_r3");

        // SUB r4,r1,r2 while instr_valid stays high with a NOP behind it
        exp_q.push_back({3'd4, 16'hFFFE});
        send(rr(OP_SUB, 3'd4, 3'd1, 3'd2));           // cycle 1
        bus.instr       = rr(4'd12, 3'd6, 3'd0, 3'd0);
        bus.instr_valid = 1'b1;
        check("busy_c1_ready", 32'(bus.instr_ready), 32'd0);
        tick();                                        // cycle 2
        check("busy_c2_ready", 32'(bus.instr_ready), 32'd0);
        check("busy_c2_state", 32'(state_dbg), 32'(S_WB));
        tick();                                        // cycle 3: NOP accepted at next edge
        check("sub_wb_data", 32'(bus.wb_data), 32'h0000FFFE);
        check("busy_c3_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        check("nop_state", 32'(state_dbg), 32'(S_IDLE));
        check("nop_ready", 32'(bus.instr_ready), 32'd1);
        check("nop_no_wb", 32'(bus.wb_valid), 32'd0);
        repeat (2) tick();
        check_reg(3'd4, 16'hFFFE, "dbg_r4");
        check_reg(3'd6, 16'h0000, "dbg_r6_nop");

        // MUL low half, then source == destination
        run(ldi(3'd1, 9'h100), 3'd1, 16'h0100);
        run(rr(OP_MUL, 3'd5, 3'd1, 3'd1), 3'd5, 16'h0000);
        run(rr(OP_ADD, 3'd1, 3'd1, 3'd1), 3'd1, 16'h0200);
        check_reg(3'd5, 16'h0000, "dbg_r5_mul");
        check_reg(3'd1, 16'h0200, "dbg_r1_self");

        // Reset during ISSUE: no write, everything cleared
        send(rr(OP_ADD, 3'd7, 3'd1, 3'd1));           // cycle 1 (ISSUE)
        check("pre_rst_alu_en", 32'(bus.alu_en), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
        check("mid_rst_alu", 32'({bus.alu_en, bus.alu_opA, bus.alu_oper}), 32'd0);
        check("mid_rst_opB", 32'(bus.alu_opB), 32'd0);
        check("mid_rst_wb", 32'({bus.wb_valid, bus.wb_addr, bus.wb_data}), 32'd0);
        repeat (3) tick();
        for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000, "mid_rst_reg");

        // r0 behaviour
`ifdef ALU_SEQ_R0_ZERO_EN
        run(ldi(3'd0, 9'd7), 3'd0, 16'd7);
        run(rr(OP_ADD, 3'd1, 3'd0, 3'd0), 3'd1, 16'd0);
        check_reg(3'd0, 16'd0, "r0_zero");
        check_reg(3'd1, 16'd0, "r1_from_r0");
`else
        run(ldi(3'd0, 9'd7), 3'd0, 16'd7);
        run(rr(OP_ADD, 3'd1, 3'd0, 3'd0), 3'd1, 16'd14);
        check_reg(3'd0, 16'd7, "r0_plain");
        check_reg(3'd1, 16'd14, "r1_from_r0");
`endif

        // ---------------- final report ----------------
        tick();
        check("wb_pending", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue/writeback stage wrapped around the registered 16-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and reads two operands from an internal 8x16 register file.
- Drives the ALU enable/operand/opcode inputs, waits one cycle for the ALU's registered result, then writes that result back to the destination register.
- Strictly one instruction in flight. No hazards, no forwarding.

Parameters:
- DATA_W, 16, datapath width; must match the ALU operand/result width.
- NREGS, 8, register file depth; fixed by the 3-bit register fields.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- instr  in  16  instruction word
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  sequencer can accept an instruction
- alu_en  out  1  to ALU alu_en
- alu_opA  out  16  to ALU operandA
- alu_opB  out  16  to ALU operandB
- alu_oper  out  4  to ALU oper
- alu_q  in  16  from ALU q
- wb_valid  out  1  one-cycle pulse: register written this cycle
- wb_addr  out  3  destination register of the write
- wb_data  out  16  data written
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational read of regfile[dbg_addr]

Behaviour:
- Instruction fields:
  - [15:12] op
  - [11:9] rd
  - [8:6] rsA
  - [5:3] rsB
  - [2:0] ignored
  - LDI uses [8:0] as imm9.
- Opcodes:
  - 0 = LDI: rd <= zero-extended imm9, no ALU use.
  - 1..11 = ALU operations, passed unchanged on alu_oper.
  - 12..15 = NOP: no write.
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr.
  - op 1..11 -> ISSUE.
  - op 0 -> WB with result = imm9; no ISSUE, alu_en stays 0.
  - op 12..15 -> stay IDLE; instruction is consumed, no write.
- ISSUE (one cycle):
  - instr_ready=0.
  - alu_en=1.
  - alu_opA=regfile[rsA], alu_opB=regfile[rsB], alu_oper=op; all registered outputs, stable for the whole cycle.
  - -> WB.
- WB (one cycle):
  - instr_ready=0, alu_en=0.
  - Result = alu_q for ALU ops, imm9 for LDI.
  - At the end-of-cycle edge: regfile[rd] <= result, and wb_valid/wb_addr/wb_data register the same write, so they are visible in the following cycle.
  - -> IDLE.
- Latency and throughput:
  - ALU ops: accept edge at cycle 0, ISSUE in cycle 1, WB in cycle 2, wb_valid=1 in cycle 3.
  - ALU-op throughput: one instruction per 3 cycles.
  - LDI: 2 cycles.
- Outside ISSUE:
  - alu_en=0.
  - alu_opA/alu_opB/alu_oper hold their last values; no toggling while idle.
- wb_valid: high exactly one cycle per write; 0 otherwise. wb_addr/wb_data hold between writes.
- Source equals destination (e.g. r1 = r1 + r1): operands are read in ISSUE, before the WB write. No conflict.
- instr_valid while busy: ignored. The upstream source must hold instr until instr_ready is seen.
- Arithmetic: no flags. Overflow and the multiply's upper bits are the ALU's concern; the 16-bit alu_q is written as-is.
- Reset (rst_n=0 at an edge), including mid-instruction:
  - FSM -> IDLE.
  - All 8 registers = 0.
  - alu_en=0, alu_opA=alu_opB=0, alu_oper=0.
  - wb_valid=0, wb_addr=0, wb_data=0.
  - instr_ready=1 in the first cycle after release.
  - The in-flight instruction is discarded with no write.
  - ALU q is unreset; it is ignored until the next WB.

Optional Feature:
- Macro: ALU_SEQ_R0_ZERO_EN.
- Defined: r0 is hardwired to 0. Reads of r0 (rsA, rsB, dbg_addr) return 0. Writes with rd=0 are discarded, but wb_valid still pulses with wb_addr=0 and wb_data = the computed result.
- Undefined: r0 is an ordinary register.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_LDI=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_SHR=6, OP_SHL=7, OP_ROR=8, OP_ROL=9, OP_NOT=10, OP_MUL=11;
  - field bit positions;
  - FSM state enum.
- One sub-module: alu_seq_regfile.
  - 8x16, synchronous reset, one write port.
  - Three combinational read ports: rsA, rsB, dbg.
  - Handles the R0 option internally.

Test Plan:
- LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> ADD accept at cycle 0; alu_en=1 only in cycle 1 with opA=5, opB=3, oper=1; wb_valid in cycle 3 with addr 3, data 8 (ALU computes B+A); dbg r3=8.
- SUB r4,r1,r2 with r1=5, r2=3 -> ALU computes B-A, wb_data=0xFFFE.
- MUL r5,r1,r1 with r1=0x0100 -> wb_data=0x0000 (low 16 bits); then ADD r1,r1,r1 -> r1=0x0200.
- instr_valid held high during ISSUE/WB -> instr_ready=0 and no second accept; the next instruction is accepted in IDLE only. NOP op=12 -> no wb_valid, instr_ready stays 1.
- Assert rst_n=0 during ISSUE -> next cycle: IDLE, all regs 0, alu_en=0, no write.
- With ALU_SEQ_R0_ZERO_EN: LDI r0,7; ADD r1,r0,r0 -> dbg r0=0, r1=0. Without the macro -> r0=7, r1=14.
